// File: rtl/wave_voice_sequencer.sv
// wave_voice_sequencer
//   Shares one registered wavetable ROM (1-cycle read latency) between
//   voices_p voices. Each voice has its own phase accumulator. On every
//   sample-frame tick, the voices enabled for that frame are served in
//   ascending index order. For each voice the block reads the ROM, presents
//   the sample on a valid/ready stream and then advances the voice's phase.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous, active-high reset
//   tick_i      sample-frame strobe (1-cycle pulse)
//   enable_i    per-voice enable, latched at frame start
//   freq_i      packed per-voice phase increments, voice v at [v*phase_width_p +: phase_width_p]
//   rom_addr_o  registered ROM read address (top AW bits of the voice phase)
//   rom_data_i  ROM read data, valid one cycle after rom_addr_o
//   data_o      sample for voice_o
//   voice_o     voice index of data_o
//   valid_o     data_o/voice_o valid
//   ready_i     downstream accepts when valid_o & ready_i
//   busy_o      frame in progress
//   overrun_o   1-cycle pulse: tick_i arrived while a frame was in progress
module wave_voice_sequencer #(
    parameter int width_p       = 12,
    parameter int depth_p       = 512,
    parameter int voices_p      = 4,
    parameter int phase_width_p = 24,
    localparam int AW           = $clog2(depth_p),
    localparam int VW           = (voices_p > 1) ? $clog2(voices_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              tick_i,
    input  logic [voices_p-1:0]               enable_i,
    input  logic [voices_p*phase_width_p-1:0] freq_i,
    output logic [AW-1:0]                     rom_addr_o,
    input  logic [width_p-1:0]                rom_data_i,
    output logic [width_p-1:0]                data_o,
    output logic [VW-1:0]                     voice_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              busy_o,
    output logic                              overrun_o
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, OUT} state_e;

    state_e                     state_q, state_d;
    logic [voices_p-1:0]        mask_q, mask_d;
    logic [VW-1:0]              v_q, v_d;
    logic [phase_width_p-1:0]   phase_q [voices_p];
    logic [phase_width_p-1:0]   phase_d [voices_p];
    logic [AW-1:0]              rom_addr_q, rom_addr_d;
    logic [width_p-1:0]         data_q, data_d;
    logic [VW-1:0]              voice_q, voice_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;

    // {found, index} of the lowest set bit of m at or above position start.
    logic [VW:0]                first_sel, next_sel;

    function automatic logic [VW:0] find_set(input logic [voices_p-1:0] m, input int start);
        logic [VW:0] res;
        res = '0;
        for (int i = 0; i < voices_p; i++) begin
            if (!res[VW] && m[i] && (i >= start)) begin
                res = {1'b1, VW'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [phase_width_p-1:0] p);
        return p[phase_width_p-1 -: AW];
    endfunction

    assign first_sel = find_set(enable_i, 0);
    assign next_sel  = find_set(mask_q, int'(v_q) + 1);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        v_d        = v_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        voice_d    = voice_q;
        valid_d    = valid_q;
        // Any tick outside IDLE is dropped; this includes a tick on the
        // same edge that OUT returns to IDLE.
        overrun_d  = tick_i && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    mask_d = enable_i;
                    // Voices sitting out this frame restart from phase 0.
                    for (int i = 0; i < voices_p; i++) begin
                        if (!enable_i[i]) begin
                            phase_d[i] = '0;
                        end
                    end
                    if (first_sel[VW]) begin
                        v_d        = first_sel[VW-1:0];
                        rom_addr_d = addr_of(phase_q[first_sel[VW-1:0]]);
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                state_d = CAPT;
            end
            CAPT: begin
                data_d  = rom_data_i;
                voice_d = v_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (ready_i) begin
                    phase_d[v_q] = phase_q[v_q] + freq_i[int'(v_q)*phase_width_p +: phase_width_p];
                    valid_d      = 1'b0;
                    if (next_sel[VW]) begin
                        // Next voice differs from v_q, so its phase is not
                        // being updated this cycle.
                        v_d        = next_sel[VW-1:0];
                        rom_addr_d = addr_of(phase_q[next_sel[VW-1:0]]);
                        state_d    = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            v_q        <= '0;
            rom_addr_q <= '0;
            data_q     <= '0;
            voice_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < voices_p; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            v_q        <= v_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
            voice_q    <= voice_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < voices_p; i++) begin
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign data_o     = data_q;
    assign voice_o    = voice_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q != IDLE);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_wave_voice_sequencer.sv
// Testbench for wave_voice_sequencer: registered ROM model, behavioural
// phase model per voice, directed frames followed by randomized frames.
module tb_wave_voice_sequencer;

    localparam int W  = 12;
    localparam int D  = 512;
    localparam int NV = 4;
    localparam int PW = 24;
    localparam int AW = 9;
    localparam int VW = 2;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             tick_i;
    logic [NV-1:0]    enable_i;
    logic [NV*PW-1:0] freq_i;
    logic [AW-1:0]    rom_addr_o;
    logic [W-1:0]     rom_data_i;
    logic [W-1:0]     data_o;
    logic [VW-1:0]    voice_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;
    logic             overrun_o;

    always #5 clk = ~clk;

    wave_voice_sequencer #(
        .width_p(W), .depth_p(D), .voices_p(NV), .phase_width_p(PW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .enable_i(enable_i),
        .freq_i(freq_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .data_o(data_o), .voice_o(voice_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    // Distinct contents for every address (a*7 + 0x155 stays below 4096).
    function automatic logic [W-1:0] rom_fn(input logic [AW-1:0] a);
        int t;
        t = int'(a) * 7 + 'h155;
        return W'(t);
    endfunction

    always @(posedge clk) rom_data_i <= rom_fn(rom_addr_o);

    int vectors    = 0;
    int miscompares = 0;

    logic [PW-1:0] ph [NV];
    logic [AW-1:0] last_addr;

    function automatic logic [AW-1:0] addr_of(input logic [PW-1:0] p);
        return AW'(p / (1 << (PW - AW)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        for (int v = 0; v < NV; v++) ph[v] = '0;
    endtask

    // One full frame. rdly < 0 picks a random ready delay per voice.
    task automatic frame(input logic [NV-1:0] en, input int rdly, input bit rnd);
        int cnt;
        int d;
        logic [W-1:0] exp_d;
        enable_i = en;
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        if (rnd) enable_i = NV'($urandom);
        for (int v = 0; v < NV; v++) if (!en[v]) ph[v] = '0;
        if (en == '0) begin
            step();
            check("idle_busy", busy_o, 0);
            check("idle_valid", valid_o, 0);
            return;
        end
        for (int v = 0; v < NV; v++) begin
            if (en[v]) begin
                cnt = 0;
                while (!valid_o && cnt < 8) begin
                    step();
                    cnt++;
                end
                check("latency", cnt, 2);
                if (!valid_o) return;
                exp_d = rom_fn(addr_of(ph[v]));
                check("voice", voice_o, v);
                check("data", data_o, exp_d);
                check("addr", rom_addr_o, addr_of(ph[v]));
                last_addr = rom_addr_o;
                d = (rdly < 0) ? $urandom_range(0, 4) : rdly;
                for (int k = 0; k < d; k++) begin
                    step();
                    check("hold_valid", valid_o, 1);
                    check("hold_data", data_o, exp_d);
                    check("hold_voice", voice_o, v);
                end
                if (rnd) freq_i = {$urandom, $urandom, $urandom};
                ready_i = 1'b1;
                step();
                ready_i = 1'b0;
                ph[v] = ph[v] + freq_i[v*PW +: PW];
                check("post_hs_valid", valid_o, 0);
            end
        end
        check("end_busy", busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_i  = 1'b1;
        tick_i   = 1'b0;
        enable_i = '0;
        freq_i   = '0;
        ready_i  = 1'b0;
        do_reset();
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_addr", rom_addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_voice", voice_o, 0);

        // Single voice stepping one ROM address per frame.
        freq_i[0 +: PW] = 24'h008000;
        for (int f = 0; f < 4; f++) begin
            frame(4'b0001, 0, 1'b0);
            check("t1_addr", last_addr, f);
            repeat (14) step();
        end

        // Voices 1 and 3 only.
        freq_i = {NV{24'h010000}};
        frame(4'b1010, 0, 1'b0);
        check("t2_addr3", last_addr, 0);

        // Long backpressure, then a single phase advance.
        frame(4'b0001, 10, 1'b0);
        frame(4'b0001, 0, 1'b0);
        check("t3_addr", last_addr, 2);

        // Phase wraparound.
        do_reset();
        freq_i[0 +: PW] = 24'hFFFFFF;
        frame(4'b0001, 0, 1'b0);
        check("t4_addr_f1", last_addr, 0);
        frame(4'b0001, 0, 1'b0);
        check("t4_addr_f2", last_addr, 511);
        frame(4'b0001, 0, 1'b0);
        check("t4_addr_f3", last_addr, 511);

        // Tick two cycles into a frame.
        enable_i = 4'b0001;
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        check("t5_ovr_e0", overrun_o, 0);
        step();
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        check("t5_ovr_pulse", overrun_o, 1);
        check("t5_valid", valid_o, 1);
        check("t5_data", data_o, rom_fn(addr_of(ph[0])));
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        ph[0] = ph[0] + freq_i[0 +: PW];
        check("t5_ovr_clear", overrun_o, 0);
        check("t5_busy_end", busy_o, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t5_no_frame_valid", valid_o, 0);
            check("t5_no_frame_busy", busy_o, 0);
        end

        // Tick on the edge the frame finishes.
        enable_i = 4'b0001;
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        step();
        step();
        check("t5b_valid", valid_o, 1);
        ready_i = 1'b1;
        tick_i  = 1'b1;
        step();
        ready_i = 1'b0;
        tick_i  = 1'b0;
        ph[0] = ph[0] + freq_i[0 +: PW];
        check("t5b_ovr", overrun_o, 1);
        check("t5b_busy", busy_o, 0);
        step();
        check("t5b_ovr_clear", overrun_o, 0);
        check("t5b_no_frame", busy_o, 0);

        // Reset while holding a sample in OUT.
        freq_i = {$urandom, $urandom, $urandom};
        frame(4'b0111, 0, 1'b0);
        enable_i = 4'b0110;
        tick_i   = 1'b1;
        step();
        tick_i   = 1'b0;
        step();
        step();
        check("t6_valid_pre", valid_o, 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        for (int v = 0; v < NV; v++) ph[v] = '0;
        check("t6_valid", valid_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_addr", rom_addr_o, 0);
        check("t6_data", data_o, 0);
        frame(4'b0110, 0, 1'b0);

        // Randomized frames.
        for (int n = 0; n < 12; n++) begin
            freq_i = {$urandom, $urandom, $urandom};
            frame(NV'($urandom), -1, 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
